trap_controller: RTL and testbench
==================================

// Module: trap_controller
// PURPOSE
//  Parametrised exception/trap unit for the MEM stage. Detects load/store misalignment
//  per access size (byte/half/word). Arbitrates it against NUM_SRC external exception
//  sources and captures mcause/mepc/mtval. Sequences pipeline flush, redirect to the
//  trap vector and return on mret.
//  Sits between the MEM stage, the pipeline control (flush/drain) and fetch (redirect).
// PARAMETERS
//  XLEN      32            datapath/address width
//  NUM_SRC   4             external exception sources; index 0 = highest priority
//  CAUSE_W   5             width of each external cause code
//  TRAP_VEC  32'h0000_0100 redirect target on trap entry
//  CNT_W     16            width of saturating trap counter
// PORTS
//  clk            in   1               clock, rising edge
//  reset_n        in   1               asynchronous, active-low reset
//  mem_valid      in   1               MEM-stage instruction valid
//  mem_opcode     in   7               opcode (LOAD 7'b0000011, STORE 7'b0100011)
//  mem_funct3     in   3               access size: x00 byte, x01 half, 010 word
//  mem_addr       in   XLEN            effective memory address
//  mem_pc         in   XLEN            PC of the MEM-stage instruction
//  ext_exc_valid  in   NUM_SRC         external exception requests
//  ext_exc_cause  in   NUM_SRC*CAUSE_W packed cause codes, src i at [i*CAUSE_W+:CAUSE_W]
//  ext_exc_pc     in   NUM_SRC*XLEN    packed faulting PCs
//  drain_done     in   1               pipeline reports flush complete
//  mret           in   1               handler executed mret
//  exception      out  1               1-cycle pulse on trap entry
//  flush          out  1               held high in FLUSH state
//  redirect_valid out  1               1-cycle fetch redirect strobe
//  redirect_pc    out  XLEN            redirect target
//  mcause         out  XLEN            captured cause
//  mepc           out  XLEN            captured faulting PC
//  mtval          out  XLEN            faulting address (TRAP_MTVAL_EN only, else 0)
//  busy           out  1               state != IDLE
//  double_fault   out  1               sticky; request seen while in HANDLER
//  trap_count     out  CNT_W           saturating count of accepted traps
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, CSRs, counter and sticky flag = 0, immediately.
//  Misaligned: LOAD/STORE and (half with addr[0]) or (word with addr[1:0]!=0).
//   Byte accesses never fault. funct3 011/110/111 is never flagged.
//  Cause: load misaligned = 4, store misaligned = 6; external cause zero-extended.
//  Priority: misaligned (needs mem_valid) > ext[0] > ... > ext[NUM_SRC-1].
//  IDLE: any request at edge N -> FLUSH at N.
//   Same edge: capture mcause/mepc(/mtval), exception=1 for one cycle, flush=1, trap_count+1.
//   mepc=mem_pc for misaligned, ext_exc_pc[i] for external.
//  FLUSH: flush held 1. Requests are ignored.
//   drain_done sampled only here; when high -> REDIRECT, flush=0.
//  REDIRECT: redirect_valid=1, redirect_pc=TRAP_VEC for one cycle -> HANDLER.
//  HANDLER: mret -> RETURN.
//   Any request here -> double_fault=1 (sticky until reset); CSRs unchanged.
//  RETURN: redirect_valid=1, redirect_pc=mepc+4 for one cycle -> IDLE.
//  mret outside HANDLER ignored. trap_count saturates at all-ones.
//  Reset asserted mid-sequence: abort to IDLE, flush/redirect drop immediately.
// CONFIGURATION
//  TRAP_MTVAL_EN defined:
//   mtval = mem_addr on misaligned; 0 on external traps.
//  Undefined:
//   mtval tied to 0, no mtval register synthesised.
// STRUCTURE
//  trap_pkg: opcode/cause localparams, funct3 size codes, state encoding
//   (IDLE, FLUSH, REDIRECT, HANDLER, RETURN).
//  Sub-module align_checker: combinational opcode/funct3/addr -> misaligned, is_store.
//  Priority select and FSM in trap_controller.
// TESTING
//  LW addr 0x1002 -> exception 1 cycle, mcause 4, mepc=mem_pc, flush until drain_done.
//  Full sequence: redirect_pc 0x100; after mret, redirect_pc = mepc+4; busy then 0.
//  SH addr 0x2001 -> mcause 6; SH 0x2002 and SB 0x2003 -> no exception.
//  Misaligned LW with ext_exc_valid=4'b0110 in the same cycle:
//   misaligned wins. Ext only -> src 1 wins, mepc=its PC.
//  Ext request during HANDLER -> double_fault=1, mcause/mepc unchanged.
//  Then mret -> normal return; double_fault stays 1.
//  reset_n low while in FLUSH -> all outputs 0 asynchronously.
//   With TRAP_MTVAL_EN, check mtval=0x1002 for the LW case.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared encodings for the MEM-stage trap unit: opcodes, access sizes, causes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trap_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // funct3 size codes; bit 2 only distinguishes signed/unsigned loads
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam int unsigned CAUSE_LOAD_MISALIGN  = 4;
    localparam int unsigned CAUSE_STORE_MISALIGN = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT,
        ST_HANDLER,
        ST_RETURN
    } trap_state_e;

endpackage

// File: rtl/align_checker.sv
// Flags misaligned loads/stores from opcode, access size and low address bits.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module align_checker
    import trap_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    output logic       misaligned_o,
    output logic       is_store_o
);

    logic is_load;
    logic is_store;
    logic half_bad;
    logic word_bad;

    assign is_load  = (opcode_i == OP_LOAD);
    assign is_store = (opcode_i == OP_STORE);

    // Bytes never fault; 011/110/111 match neither pattern so are never flagged.
    assign half_bad = (funct3_i[1:0] == SZ_HALF) && addr_lo_i[0];
    assign word_bad = (funct3_i == F3_WORD) && (addr_lo_i != 2'b00);

    assign misaligned_o = (is_load || is_store) && (half_bad || word_bad);
    assign is_store_o   = is_store;

endmodule

// File: rtl/trap_controller.sv
// MEM-stage trap unit: picks misaligned vs external exceptions, captures CSRs, runs flush/redirect/mret.
// Latency: trap entry registered at the request edge; one-cycle redirect strobes on entry and return.
// Backpressure: FLUSH waits on drain_done, HANDLER waits on mret; new requests ignored while busy.
// Optional mtval capture: define TRAP_MTVAL_EN.
module trap_controller
    import trap_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NUM_SRC  = 4,
    parameter int unsigned     CAUSE_W  = 5,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       mem_valid,
    input  logic [6:0]                 mem_opcode,
    input  logic [2:0]                 mem_funct3,
    input  logic [XLEN-1:0]            mem_addr,
    input  logic [XLEN-1:0]            mem_pc,
    input  logic [NUM_SRC-1:0]         ext_exc_valid,
    input  logic [NUM_SRC*CAUSE_W-1:0] ext_exc_cause,
    input  logic [NUM_SRC*XLEN-1:0]    ext_exc_pc,
    input  logic                       drain_done,
    input  logic                       mret,
    output logic                       exception,
    output logic                       flush,
    output logic                       redirect_valid,
    output logic [XLEN-1:0]            redirect_pc,
    output logic [XLEN-1:0]            mcause,
    output logic [XLEN-1:0]            mepc,
    output logic [XLEN-1:0]            mtval,
    output logic                       busy,
    output logic                       double_fault,
    output logic [CNT_W-1:0]           trap_count
);

    trap_state_e      state_q;
    logic             exception_q;
    logic             flush_q;
    logic             redirect_valid_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic [XLEN-1:0]  mcause_q;
    logic [XLEN-1:0]  mepc_q;
    logic             double_fault_q;
    logic [CNT_W-1:0] trap_count_q;

    logic            misaligned;
    logic            is_store;
    logic            mis_req;
    logic            any_req;
    logic [XLEN-1:0] sel_cause;
    logic [XLEN-1:0] sel_pc;

    align_checker u_align (
        .opcode_i     (mem_opcode),
        .funct3_i     (mem_funct3),
        .addr_lo_i    (mem_addr[1:0]),
        .misaligned_o (misaligned),
        .is_store_o   (is_store)
    );

    assign mis_req = mem_valid && misaligned;
    assign any_req = mis_req || (|ext_exc_valid);

    // Priority select: misaligned first, else lowest-index external source wins.
    always_comb begin
        sel_cause = is_store ? XLEN'(CAUSE_STORE_MISALIGN) : XLEN'(CAUSE_LOAD_MISALIGN);
        sel_pc    = mem_pc;
        if (!mis_req) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (ext_exc_valid[i]) begin
                    sel_cause = XLEN'(ext_exc_cause[i*CAUSE_W +: CAUSE_W]);
                    sel_pc    = ext_exc_pc[i*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef TRAP_MTVAL_EN
    logic [XLEN-1:0] mtval_q;

    // mtval holds the faulting address for misaligned traps, zero for external ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtval_q <= '0;
        end else if (state_q == ST_IDLE && any_req) begin
            mtval_q <= mis_req ? mem_addr : '0;
        end
    end

    assign mtval = mtval_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[XLEN-1:2];
    assign mtval          = '0;
`endif

    // Trap sequencing FSM with registered strobes, CSR capture and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            exception_q      <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mcause_q         <= '0;
            mepc_q           <= '0;
            double_fault_q   <= 1'b0;
            trap_count_q     <= '0;
        end else begin
            exception_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q     <= ST_FLUSH;
                        exception_q <= 1'b1;
                        flush_q     <= 1'b1;
                        mcause_q    <= sel_cause;
                        mepc_q      <= sel_pc;
                        if (trap_count_q != '1) begin
                            trap_count_q <= trap_count_q + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (drain_done) begin
                        state_q          <= ST_REDIRECT;
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= TRAP_VEC;
                    end
                end
                ST_REDIRECT: begin
                    state_q <= ST_HANDLER;
                end
                ST_HANDLER: begin
                    // A nested request cannot be serviced; record it and keep the CSRs.
                    if (any_req) begin
                        double_fault_q <= 1'b1;
                    end
                    if (mret) begin
                        state_q          <= ST_RETURN;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= mepc_q + XLEN'(4);
                    end
                end
                ST_RETURN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign exception      = exception_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mcause         = mcause_q;
    assign mepc           = mepc_q;
    assign busy           = (state_q != ST_IDLE);
    assign double_fault   = double_fault_q;
    assign trap_count     = trap_count_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: misalignment detection, priority, full trap/return sequence.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: drain_done and mret driven explicitly by the stimulus.
module tb_trap_controller;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 4;
    localparam int CAUSE_W = 5;
    localparam int CNT_W   = 16;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b1;
    logic                       mem_valid;
    logic [6:0]                 mem_opcode;
    logic [2:0]                 mem_funct3;
    logic [XLEN-1:0]            mem_addr;
    logic [XLEN-1:0]            mem_pc;
    logic [NUM_SRC-1:0]         ext_exc_valid;
    logic [NUM_SRC*CAUSE_W-1:0] ext_exc_cause;
    logic [NUM_SRC*XLEN-1:0]    ext_exc_pc;
    logic                       drain_done;
    logic                       mret;
    logic                       exception;
    logic                       flush;
    logic                       redirect_valid;
    logic [XLEN-1:0]            redirect_pc;
    logic [XLEN-1:0]            mcause;
    logic [XLEN-1:0]            mepc;
    logic [XLEN-1:0]            mtval;
    logic                       busy;
    logic                       double_fault;
    logic [CNT_W-1:0]           trap_count;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    trap_controller u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_valid      (mem_valid),
        .mem_opcode     (mem_opcode),
        .mem_funct3     (mem_funct3),
        .mem_addr       (mem_addr),
        .mem_pc         (mem_pc),
        .ext_exc_valid  (ext_exc_valid),
        .ext_exc_cause  (ext_exc_cause),
        .ext_exc_pc     (ext_exc_pc),
        .drain_done     (drain_done),
        .mret           (mret),
        .exception      (exception),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mcause         (mcause),
        .mepc           (mepc),
        .mtval          (mtval),
        .busy           (busy),
        .double_fault   (double_fault),
        .trap_count     (trap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid     = 1'b0;
        mem_opcode    = 7'b0;
        mem_funct3    = 3'b0;
        mem_addr      = '0;
        mem_pc        = '0;
        ext_exc_valid = '0;
        drain_done    = 1'b0;
        mret          = 1'b0;
    endtask

    task automatic mem_op(input logic [6:0] op, input logic [2:0] f3,
                          input logic [XLEN-1:0] addr, input logic [XLEN-1:0] pc);
        mem_valid  = 1'b1;
        mem_opcode = op;
        mem_funct3 = f3;
        mem_addr   = addr;
        mem_pc     = pc;
    endtask

    // Drives drain_done then mret; checks both redirect strobes and the return to idle.
    task automatic finish_trap(input string tag, input logic [XLEN-1:0] ret_pc);
        drain_done = 1'b1;
        step();
        drain_done = 1'b0;
        check({tag, "_redir_vld"}, redirect_valid, 1);
        check({tag, "_redir_vec"}, redirect_pc, 32'h100);
        check({tag, "_redir_flush"}, flush, 0);
        step();
        check({tag, "_handler_vld"}, redirect_valid, 0);
        mret = 1'b1;
        step();
        mret = 1'b0;
        check({tag, "_ret_vld"}, redirect_valid, 1);
        check({tag, "_ret_pc"}, redirect_pc, ret_pc);
        step();
        check({tag, "_ret_busy"}, busy, 0);
        check({tag, "_ret_vld_off"}, redirect_valid, 0);
    endtask

    initial begin
        idle_inputs();
        ext_exc_cause = {5'd25, 5'd17, 5'd11, 5'd3};
        ext_exc_pc    = {32'h1000_0030, 32'h1000_0020, 32'h1000_0010, 32'h1000_0000};

        #1 reset_n = 1'b0;
        repeat (2) step();
        check("rst_exception", exception, 0);
        check("rst_flush", flush, 0);
        check("rst_busy", busy, 0);
        check("rst_mcause", mcause, 0);
        check("rst_count", trap_count, 0);
        check("rst_redir", redirect_valid, 0);
        reset_n = 1'b1;
        step();

        // LW to 0x1002: misaligned load
        mem_op(LOAD, 3'b010, 32'h1002, 32'h400);
        step();
        idle_inputs();
        check("lw_exception", exception, 1);
        check("lw_flush", flush, 1);
        check("lw_mcause", mcause, 4);
        check("lw_mepc", mepc, 32'h400);
        check("lw_busy", busy, 1);
        check("lw_count", trap_count, 1);
`ifdef TRAP_MTVAL_EN
        check("lw_mtval", mtval, 32'h1002);
`else
        check("lw_mtval", mtval, 0);
`endif
        step();
        check("lw_exc_pulse", exception, 0);
        check("lw_flush_hold", flush, 1);
        mem_op(LOAD, 3'b010, 32'h1001, 32'h500);
        step();
        idle_inputs();
        check("flush_ignores_req", mcause, 4);
        check("flush_ignores_cnt", trap_count, 1);
        finish_trap("lw", 32'h404);

        // mret outside HANDLER has no effect
        mret = 1'b1;
        step();
        mret = 1'b0;
        check("idle_mret_vld", redirect_valid, 0);
        check("idle_mret_busy", busy, 0);

        // SH to odd address: store misaligned
        mem_op(STORE, 3'b001, 32'h2001, 32'h600);
        step();
        idle_inputs();
        check("sh_exception", exception, 1);
        check("sh_mcause", mcause, 6);
        check("sh_mepc", mepc, 32'h600);
        check("sh_count", trap_count, 2);
        finish_trap("sh", 32'h604);

        // Aligned half, byte and the reserved 011 size never trap
        mem_op(STORE, 3'b001, 32'h2002, 32'h700);
        step();
        check("sh_aligned", exception, 0);
        mem_op(STORE, 3'b000, 32'h2003, 32'h704);
        step();
        check("sb_any", exception, 0);
        mem_op(LOAD, 3'b011, 32'h2003, 32'h708);
        step();
        check("f3_011", exception, 0);
        mem_op(LOAD, 3'b101, 32'h2003, 32'h70c);
        step();
        idle_inputs();
        check("lhu_odd", exception, 1);
        check("lhu_mcause", mcause, 4);
        finish_trap("lhu", 32'h710);
        check("nofault_busy", busy, 0);
        check("nofault_count", trap_count, 3);

        // Misaligned beats concurrent external requests
        mem_op(LOAD, 3'b010, 32'h1002, 32'h800);
        ext_exc_valid = 4'b0110;
        step();
        idle_inputs();
        check("prio_mis_mcause", mcause, 4);
        check("prio_mis_mepc", mepc, 32'h800);
        check("prio_mis_count", trap_count, 4);
`ifdef TRAP_MTVAL_EN
        check("prio_mis_mtval", mtval, 32'h1002);
`endif
        finish_trap("prio_mis", 32'h804);

        // External only (misaligned access not valid): source 1 wins
        mem_op(LOAD, 3'b010, 32'h1002, 32'h900);
        mem_valid     = 1'b0;
        ext_exc_valid = 4'b0110;
        step();
        idle_inputs();
        check("ext_exception", exception, 1);
        check("ext_mcause", mcause, 11);
        check("ext_mepc", mepc, 32'h1000_0010);
        check("ext_count", trap_count, 5);
        check("ext_mtval", mtval, 0);
        drain_done = 1'b1;
        step();
        drain_done = 1'b0;
        step();
        check("handler_busy", busy, 1);
        check("handler_df_clear", double_fault, 0);

        // Nested request while in HANDLER
        ext_exc_valid = 4'b0001;
        step();
        idle_inputs();
        check("df_set", double_fault, 1);
        check("df_mcause", mcause, 11);
        check("df_mepc", mepc, 32'h1000_0010);
        check("df_count", trap_count, 5);
        check("df_no_exc", exception, 0);
        mret = 1'b1;
        step();
        mret = 1'b0;
        check("df_ret_vld", redirect_valid, 1);
        check("df_ret_pc", redirect_pc, 32'h1000_0014);
        step();
        check("df_ret_busy", busy, 0);
        check("df_sticky", double_fault, 1);

        // Asynchronous reset while flushing
        ext_exc_valid = 4'b1000;
        step();
        idle_inputs();
        check("pre_rst_mcause", mcause, 25);
        step();
        check("pre_rst_flush", flush, 1);
        reset_n = 1'b0;
        #1;
        check("arst_flush", flush, 0);
        check("arst_busy", busy, 0);
        check("arst_mcause", mcause, 0);
        check("arst_mepc", mepc, 0);
        check("arst_df", double_fault, 0);
        check("arst_count", trap_count, 0);
        check("arst_redir", redirect_valid, 0);
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
